// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg
//   Shared definitions for the CPU inter-stage pipeline registers.
//   - Stage payload field widths and bit offsets, so every stage packs its
//     bundle the same way.
//   - Reset/INIT constants for valid bits, data and counters.
//   - Default stall-counter width.
package pipe_stage_reg_pkg;

    // Default stall counter width used by pipe_stage_reg and the hazard unit
    localparam int CNT_W_DEF = 16;

    // Stage payload field widths
    localparam int PC_W     = 32;
    localparam int ALU_W    = 32;
    localparam int MEMD_W   = 32;
    localparam int WBSRC_W  = 2;
    localparam int RD_W     = 5;
    localparam int REGWE_W  = 1;

    // Field offsets, packed LSB-first: regwe | rd | wbsrc | memd | alu | pc
    localparam int REGWE_OFS = 0;
    localparam int RD_OFS    = REGWE_OFS + REGWE_W;
    localparam int WBSRC_OFS = RD_OFS    + RD_W;
    localparam int MEMD_OFS  = WBSRC_OFS + WBSRC_W;
    localparam int ALU_OFS   = MEMD_OFS  + MEMD_W;
    localparam int PC_OFS    = ALU_OFS   + ALU_W;
    localparam int BUNDLE_W  = PC_OFS    + PC_W;

    // Reset values
    localparam logic INIT_VALID    = 1'b0;
    localparam logic INIT_DATA_BIT = 1'b0;
    localparam logic INIT_CNT_BIT  = 1'b0;

endpackage

// File: rtl/pipe_stall_counter.sv
// pipe_stall_counter
//   Saturating event counter with synchronous clear. Clear wins over
//   increment; the count sticks at all-ones once reached.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset (count -> 0)
//   clr   - synchronous clear
//   inc   - count this cycle
//   cnt_o - current count
module pipe_stall_counter
    import pipe_stage_reg_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CNT_W{INIT_CNT_BIT}};
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CNT_W{INIT_CNT_BIT}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Inter-stage pipeline register with valid/ready handshake, synchronous
//   flush, optional skid entry (registered in_ready) and a saturating
//   stall-cycle counter.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   flush             - kill held entries and the current input
//   in_valid/in_ready - upstream handshake, in_data payload
//   out_valid/out_ready - downstream handshake, out_data payload
//   stall_cnt         - cycles with out_valid & !out_ready (saturating)
//   clr_cnt           - synchronous clear of stall_cnt
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter bit SKID_EN = 1'b1,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              clr_cnt
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    // Low during reset and set on the first edge after it, so in_ready
    // stays low while rst is asserted.
    logic              alive_q;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_valid_q & out_ready;

    generate
        if (SKID_EN) begin : g_skid
            // Built only from flops, so no combinational path from out_ready.
            assign in_ready = alive_q & ~skid_valid_q;

            always_comb begin
                main_valid_d = main_valid_q;
                main_data_d  = main_data_q;
                skid_valid_d = skid_valid_q;
                skid_data_d  = skid_data_q;
                if (flush) begin
                    // Only the valid bits drop; data registers hold.
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end else if (skid_valid_q) begin
                    // in_ready is low here, so no input can collide.
                    if (out_fire) begin
                        main_data_d  = skid_data_q;
                        skid_valid_d = 1'b0;
                    end
                end else if (main_valid_q) begin
                    if (out_ready) begin
                        main_valid_d = in_fire;
                        if (in_fire) begin
                            main_data_d = in_data;
                        end
                    end else if (in_fire) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = in_data;
                    end
                end else if (in_fire) begin
                    main_valid_d = 1'b1;
                    main_data_d  = in_data;
                end
            end
        end else begin : g_noskid
            assign in_ready = alive_q & (~main_valid_q | out_ready);

            always_comb begin
                main_valid_d = main_valid_q;
                main_data_d  = main_data_q;
                skid_valid_d = 1'b0;
                skid_data_d  = skid_data_q;
                if (flush) begin
                    main_valid_d = 1'b0;
                end else if (in_fire) begin
                    main_valid_d = 1'b1;
                    main_data_d  = in_data;
                end else if (out_fire) begin
                    main_valid_d = 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive_q      <= 1'b0;
            main_valid_q <= INIT_VALID;
            skid_valid_q <= INIT_VALID;
            main_data_q  <= {DATA_W{INIT_DATA_BIT}};
            skid_data_q  <= {DATA_W{INIT_DATA_BIT}};
        end else begin
            alive_q      <= 1'b1;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

    pipe_stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_cnt),
        .inc   (main_valid_q & ~out_ready),
        .cnt_o (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//   Directed bench for pipe_stage_reg (SKID_EN=1, CNT_W=4): reset release,
//   streaming, back-pressure through the skid entry, flush, asynchronous
//   reset mid-operation, and stall counter saturation/clear.
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;
    logic              clr_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    pipe_stage_reg #(
        .DATA_W  (DATA_W),
        .SKID_EN (1'b1),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt),
        .clr_cnt   (clr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        clr_cnt   = 1'b0;

        // Reset held for 3 cycles
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        tick();
        tick();

        // Release; in_ready comes up after the first edge
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000_1234;
        out_ready = 1'b1;
        tick();
        chk("rel_in_ready",  32'(in_ready),  32'd1);
        chk("rel_out_empty", 32'(out_valid), 32'd0);
        tick();
        chk("rel_out_valid", 32'(out_valid), 32'd1);
        chk("rel_out_data",  out_data,       32'h0000_1234);
        chk("rel_stall_cnt", 32'(stall_cnt), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("rel_drain", 32'(out_valid), 32'd0);

        // Streaming 1..8 back to back
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            tick();
            chk("strm_valid", 32'(out_valid), 32'd1);
            chk("strm_data",  out_data,       32'(i));
            chk("strm_ready", 32'(in_ready),  32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("strm_drain", 32'(out_valid), 32'd0);

        // Back-pressure: A in main, B in skid, C waits upstream
        in_valid = 1'b1;
        in_data  = 32'hA;
        tick();
        out_ready = 1'b0;
        in_data   = 32'hB;
        tick();
        chk("bp_hold_a",   out_data,       32'hA);
        chk("bp_ready_lo", 32'(in_ready),  32'd0);
        chk("bp_cnt1",     32'(stall_cnt), 32'd1);
        in_data = 32'hC;
        tick();
        tick();
        tick();
        chk("bp_still_a",  out_data,       32'hA);
        chk("bp_valid",    32'(out_valid), 32'd1);
        chk("bp_ready_lo2", 32'(in_ready), 32'd0);
        chk("bp_cnt4",     32'(stall_cnt), 32'd4);
        out_ready = 1'b1;
        tick();
        chk("bp_out_b",    out_data,       32'hB);
        chk("bp_ready_hi", 32'(in_ready),  32'd1);
        tick();
        chk("bp_out_c",    out_data,       32'hC);
        chk("bp_c_valid",  32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("bp_drain",    32'(out_valid), 32'd0);
        chk("bp_cnt_keep", 32'(stall_cnt), 32'd4);

        // Flush with main and skid full and C offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        chk("fl_skid_full", 32'(in_ready), 32'd0);
        in_data = 32'h33;
        flush   = 1'b1;
        tick();
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_in_ready",  32'(in_ready),  32'd1);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("fl_no_c", 32'(out_valid), 32'd0);
        // Flush kills an accepted input in the same cycle
        in_valid = 1'b1;
        in_data  = 32'h44;
        flush    = 1'b1;
        tick();
        chk("fl_kill_in", 32'(out_valid), 32'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("fl_kill_in2", 32'(out_valid), 32'd0);

        // Asynchronous reset between edges
        in_valid = 1'b1;
        in_data  = 32'h55;
        tick();
        in_valid = 1'b0;
        chk("ar_loaded", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_in_ready",  32'(in_ready),  32'd0);
        chk("ar_cnt",       32'(stall_cnt), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("ar_rel_ready", 32'(in_ready), 32'd1);

        // Saturation and clear
        in_valid = 1'b1;
        in_data  = 32'h66;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cnt",  32'(stall_cnt), 32'd15);
        chk("sat_hold", out_data,       32'h66);
        clr_cnt = 1'b1;
        tick();
        chk("clr_cnt0", 32'(stall_cnt), 32'd0);
        clr_cnt = 1'b0;
        tick();
        chk("clr_cnt1", 32'(stall_cnt), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("sat_drain", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the CPU pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds the following to plain per-cycle latching:
  - valid/ready handshake (stall back-pressure)
  - synchronous flush (bubble insertion for branches and exceptions)
  - optional skid entry, so ready is a registered signal
  - saturating stall-cycle counter for performance monitoring
- Each stage instantiates one copy with its packed control/data bundle as payload.

Parameters:
- DATA_W, 32: payload width in bits. Stages pack their fields into one vector.
- SKID_EN, 1:
  - 1 = two-entry (main + skid), in_ready registered.
  - 0 = single entry, in_ready combinational.
- CNT_W, 16: stall counter width.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset, asynchronous and active-high.
- flush, input, 1: synchronous kill of all held entries and of the current input.
- in_valid, input, 1: upstream payload valid.
- in_ready, output, 1: block accepts payload this cycle.
- in_data, input, DATA_W: upstream payload.
- out_valid, output, 1: downstream payload valid.
- out_ready, input, 1: downstream accepts.
- out_data, output, DATA_W: payload to downstream.
- stall_cnt, output, CNT_W: cycles with out_valid=1 and out_ready=0, saturating.
- clr_cnt, input, 1: synchronous clear of stall_cnt.

Behaviour:
- Reset (async, rst=1): main_valid=0, skid_valid=0, out_data=0, skid data=0, stall_cnt=0. The outputs are therefore out_valid=0 and in_ready=0 while rst=1. in_ready rises the first cycle after rst deasserts.
- Transfer definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Latency: 1 cycle, in_fire at edge N gives out_valid=1 after edge N, data equal to in_data.
- SKID_EN=1:
  - in_ready = !skid_valid, registered and independent of out_ready.
  - Main empty, in_fire: load main.
  - Main full, out_fire and in_fire: main <= in_data.
  - Main full, skid empty, out_ready=0, in_fire: load skid; in_ready drops next cycle.
  - out_fire with skid full: main <= skid, skid empties, in_ready rises next cycle.
  - Skid full, out_fire: no new input can arrive in the same cycle (in_ready=0), so no conflict.
- SKID_EN=0:
  - in_ready = !main_valid | out_ready.
  - in_fire loads main.
  - out_fire without in_fire clears main_valid.
- Ordering: strictly FIFO. Payload is never duplicated or dropped except by flush.
- Flush (priority over everything except reset):
  - Next edge: main_valid=0, skid_valid=0.
  - An in_fire in the same cycle is discarded.
  - Data registers keep their values; only valid bits clear.
  - out_fire in the flush cycle still counts as delivered downstream.
- Hold: with out_valid=1 and out_ready=0, out_data and out_valid stay stable until out_fire or flush.
- stall_cnt:
  - Increments each cycle out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - clr_cnt has priority over increment.
  - Flush does not clear it.
- Invalid-state payload: out_data is don't-care when out_valid=0. The bench must not check it.

Decomposition:
- Shared package/include:
  - Stage payload field widths and offsets (PC, ALU result, mem data, writeback source, dest reg, reg write enable).
  - INIT constants.
  - Default CNT_W.
- Sub-module: pipe_stall_counter (saturating counter with clear), reused by the hazard unit.
- The skid logic stays inline behind a generate on SKID_EN.

Test Plan:
- Reset release: rst high 3 cycles, low; in_valid=1, in_data=32'h0000_1234, out_ready=1 → out_valid=1, out_data=32'h1234 one cycle later; stall_cnt=0.
- Streaming: 8 back-to-back words 1..8, out_ready=1 → outputs 1..8 on consecutive cycles, in_ready constantly 1.
- Back-pressure (SKID_EN=1): stream A,B,C with out_ready=0 from the cycle A appears:
  - A held, B in skid, in_ready=0, C held upstream.
  - Raise out_ready → A,B,C delivered in order.
  - stall_cnt equals the number of stalled cycles (e.g. 4).
- Flush: main=A, skid=B, in_valid with C, flush=1 → next cycle out_valid=0, in_ready=1; C never appears.
- Async reset mid-operation: assert rst between edges while out_valid=1 → out_valid=0 immediately, before the next clk edge.
- Saturation/clear: CNT_W=4, stall for 20 cycles → stall_cnt=15. Pulse clr_cnt together with a stall cycle → stall_cnt=0.
